// File: rtl/ws2812_multi_driver_if.sv
// Frame-memory read port, control and strip outputs of the WS2812 driver.
// The brightness input exists only when WS2812_BRIGHTNESS_EN is defined.
interface ws2812_multi_driver_if #(
    parameter int NUM_STRIPS = 4,
    parameter int ADDR_W     = 13
);
    logic                    start;
    logic                    continuous;
    logic [ADDR_W-1:0]       frame_base;
    logic                    mem_en;
    logic [ADDR_W-1:0]       mem_addr;
    logic [NUM_STRIPS*8-1:0] mem_data;
    logic [NUM_STRIPS-1:0]   strip_do;
    logic                    busy;
    logic                    frame_done;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0]              brightness;

    modport master (
        output start, continuous, frame_base, mem_data, brightness,
        input  mem_en, mem_addr, strip_do, busy, frame_done
    );
    modport slave (
        input  start, continuous, frame_base, mem_data, brightness,
        output mem_en, mem_addr, strip_do, busy, frame_done
    );
`else
    modport master (
        output start, continuous, frame_base, mem_data,
        input  mem_en, mem_addr, strip_do, busy, frame_done
    );
    modport slave (
        input  start, continuous, frame_base, mem_data,
        output mem_en, mem_addr, strip_do, busy, frame_done
    );
`endif
endinterface

// File: rtl/ws2812_multi_driver.sv
// Multi-lane WS2812 driver: streams BRAM words to NUM_STRIPS serial outputs in lockstep.
// Optional WS2812_BRIGHTNESS_EN adds a per-frame brightness scale stage.
module ws2812_multi_driver #(
    parameter int NUM_STRIPS  = 4,
    parameter int NUM_BYTES   = 480,
    parameter int ADDR_W      = 13,
    parameter int MEM_LATENCY = 1,
    parameter int T_BIT       = 70,
    parameter int T0H         = 20,
    parameter int T1H         = 50,
    parameter int T_RESET     = 50000
) (
    input logic                  clk,
    input logic                  rst,
    ws2812_multi_driver_if.slave bus
);

    localparam int TMAX = (T_RESET > T_BIT) ? T_RESET : T_BIT;
    localparam int CW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam int BW   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int W    = NUM_STRIPS * 8;
`ifdef WS2812_BRIGHTNESS_EN
    localparam int CAP  = MEM_LATENCY + 1;
`else
    localparam int CAP  = MEM_LATENCY;
`endif
    localparam logic [CW:0] TH0 = (CW+1)'(T0H);
    localparam logic [CW:0] TH1 = (CW+1)'(T1H);

    generate
        if (T0H >= T1H || T1H >= T_BIT || MEM_LATENCY >= 8 * T_BIT ||
            MEM_LATENCY < 1 || MEM_LATENCY > 4 || NUM_BYTES < 1) begin : g_bad
            $error("ws2812_multi_driver: illegal timing parameters");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, GAP, FETCH, SEND} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [CW:0]       c_inc;
    logic [2:0]        bitn;
    logic [BW-1:0]     idx;
    logic [ADDR_W-1:0] base;
    logic [W-1:0]      sh;
    logic [W-1:0]      nxt;
    logic [CAP-1:0]    pipe;
    logic [W-1:0]      cap_word;
    logic              cap;

    function automatic logic hi(input logic b, input logic [CW:0] c);
        return c < (b ? TH1 : TH0);
    endfunction

    assign c_inc = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
    assign cap   = pipe[CAP-1];

`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0] bright;
    logic [W-1:0] scaled;

    function automatic logic [7:0] scale(input logic [7:0] d, input logic [7:0] b);
        logic [16:0] p;
        p = 17'(d) * 17'({1'b0, b} + 9'd1);
        return p[15:8];
    endfunction

    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_STRIPS; s++)
            scaled[8*s +: 8] <= scale(bus.mem_data[8*s +: 8], bright);
    end

    assign cap_word = scaled;
`else
    assign cap_word = bus.mem_data;
`endif

    // Read-latency tracker; the top bit marks the cycle a word is captured.
    always_ff @(posedge clk) begin
        if (rst) pipe <= '0;
        else     pipe <= CAP'({pipe, bus.mem_en});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bitn           <= '0;
            idx            <= '0;
            base           <= '0;
            sh             <= '0;
            nxt            <= '0;
            bus.mem_en     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.strip_do   <= '0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
            bright         <= '0;
`endif
        end else begin
            bus.mem_en     <= 1'b0;
            bus.frame_done <= 1'b0;
            if (cap && state == SEND) nxt <= cap_word;
            case (state)
                IDLE: begin
                    if (bus.start || bus.continuous) begin
                        base     <= bus.frame_base;
`ifdef WS2812_BRIGHTNESS_EN
                        bright   <= bus.brightness;
`endif
                        bus.busy <= 1'b1;
                        cnt      <= '0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    bus.strip_do <= '0;
                    if (cnt == CW'(T_RESET - 1)) begin
                        cnt          <= '0;
                        bus.mem_en   <= 1'b1;
                        bus.mem_addr <= base;
                        state        <= FETCH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FETCH: begin
                    if (cap) begin
                        sh    <= cap_word;
                        bitn  <= 3'd7;
                        cnt   <= '0;
                        idx   <= '0;
                        state <= SEND;
                        for (int s = 0; s < NUM_STRIPS; s++)
                            bus.strip_do[s] <= hi(cap_word[8*s+7], '0);
                        if (NUM_BYTES > 1) begin
                            bus.mem_en   <= 1'b1;
                            bus.mem_addr <= base + ADDR_W'(1);
                        end
                    end
                end
                SEND: begin
                    if (cnt == CW'(T_BIT - 1)) begin
                        cnt <= '0;
                        if (bitn == 3'd0) begin
                            if (idx == BW'(NUM_BYTES - 1)) begin
                                bus.frame_done <= 1'b1;
                                bus.strip_do   <= '0;
                                if (bus.continuous) begin
                                    base  <= bus.frame_base;
`ifdef WS2812_BRIGHTNESS_EN
                                    bright <= bus.brightness;
`endif
                                    state <= GAP;
                                end else begin
                                    bus.busy <= 1'b0;
                                    state    <= IDLE;
                                end
                            end else begin
                                sh   <= nxt;
                                bitn <= 3'd7;
                                idx  <= idx + 1'b1;
                                for (int s = 0; s < NUM_STRIPS; s++)
                                    bus.strip_do[s] <= hi(nxt[8*s+7], '0);
                                if (32'(idx) + 2 < NUM_BYTES) begin
                                    bus.mem_en   <= 1'b1;
                                    bus.mem_addr <= base + ADDR_W'(idx) + ADDR_W'(2);
                                end
                            end
                        end else begin
                            sh   <= sh << 1;
                            bitn <= bitn - 3'd1;
                            for (int s = 0; s < NUM_STRIPS; s++)
                                bus.strip_do[s] <= hi(sh[8*s+6], '0);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        for (int s = 0; s < NUM_STRIPS; s++)
                            bus.strip_do[s] <= hi(sh[8*s+7], c_inc);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
